// File: rtl/bsg_miniblade_io_reset_sequencer_pkg.sv
// Shared types and elaboration helpers for the miniblade IO reset sequencer.
package bsg_miniblade_io_reset_sequencer_pkg;

  // Sequencer phases: hold in reset, staggered release, running, draining, re-assert.
  typedef enum logic [2:0] {
    HOLD   = 3'd0,
    REL    = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    ASSERT = 3'd4
  } bsg_miniblade_rst_seq_state_e;

  // clog2 that never returns zero, so a one-value field still gets one bit.
  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  // Largest of three cycle counts; sizes the shared counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/bsg_miniblade_io_reset_sequencer_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// Clear wins over up; the count sticks at all-ones instead of wrapping.
module bsg_miniblade_io_reset_sequencer_counter #(
  parameter int unsigned width_p = 7
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] cnt_q;
  logic [width_p-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (up_i && (cnt_q != {width_p{1'b1}})) begin
      cnt_d = cnt_q + width_p'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/bsg_miniblade_io_reset_sequencer.sv
// Reset sequencer for one miniblade IO router corner: releases the router,
// then each attached domain in order with a fixed gap, and on a new request
// drains traffic (bounded by a timeout) before re-asserting every reset.
module bsg_miniblade_io_reset_sequencer
  import bsg_miniblade_io_reset_sequencer_pkg::*;
#(
  parameter int unsigned num_domains_p    = 2,
  parameter int unsigned hold_cycles_p    = 16,
  parameter int unsigned stagger_cycles_p = 4,
  parameter int unsigned drain_timeout_p  = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     tag_reset_i,
  input  logic                     idle_i,
  output logic                     rtr_reset_o,
  output logic [num_domains_p-1:0] reset_o,
  output logic                     quiesce_o,
  output logic                     ready_o,
  output logic                     timeout_o
);

  localparam int unsigned cnt_width_lp =
    safe_clog2(max3(hold_cycles_p, stagger_cycles_p, drain_timeout_p) + 1);
  localparam int unsigned k_width_lp = safe_clog2(num_domains_p);

  localparam logic [cnt_width_lp-1:0] hold_last_lp    = cnt_width_lp'(hold_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] stagger_last_lp = cnt_width_lp'(stagger_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] timeout_last_lp = cnt_width_lp'(drain_timeout_p - 1);
  localparam logic [k_width_lp-1:0]   k_last_lp       = k_width_lp'(num_domains_p - 1);

  bsg_miniblade_rst_seq_state_e state_q, state_d;

  logic [cnt_width_lp-1:0]  cnt;
  logic                     cnt_clear;
  logic                     cnt_up;

  logic [k_width_lp-1:0]    k_q, k_d;
  logic                     rtr_reset_q, rtr_reset_d;
  logic [num_domains_p-1:0] reset_o_q, reset_o_d;
  logic                     quiesce_q, quiesce_d;
  logic                     ready_q, ready_d;
  logic                     timeout_q, timeout_d;

  logic hold_done;
  logic rel_step;
  logic drain_expire;

  // Shared phase counter; zeroed on every phase change.
  bsg_miniblade_io_reset_sequencer_counter #(
    .width_p (cnt_width_lp)
  ) cnt_inst (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (cnt_clear),
    .up_i    (cnt_up),
    .count_o (cnt)
  );

  // Phase-completion conditions derived from the shared counter.
  assign hold_done    = (state_q == HOLD)  && !tag_reset_i && (cnt == hold_last_lp);
  assign rel_step     = (state_q == REL)   && !tag_reset_i && (cnt == stagger_last_lp);
  assign drain_expire = (state_q == DRAIN) && !idle_i      && (cnt == timeout_last_lp);

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a request during release skips the drain since no domain is fully up.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD:    if (hold_done) state_d = REL;
      REL: begin
        if (tag_reset_i) begin
          state_d = ASSERT;
        end else if (rel_step && (k_q == k_last_lp)) begin
          state_d = RUN;
        end
      end
      RUN:     if (tag_reset_i) state_d = DRAIN;
      DRAIN:   if (idle_i || drain_expire) state_d = ASSERT;
      ASSERT:  state_d = HOLD;
      default: state_d = HOLD;
    endcase
  end

  // Output and counter-control logic, computed from the phase being entered.
  always_comb begin
    rtr_reset_d = (state_d == HOLD) || (state_d == ASSERT);
    quiesce_d   = (state_d == DRAIN);
    ready_d     = (state_d == RUN);
    timeout_d   = timeout_q | drain_expire;

    k_d = '0;
    if (state_d == REL) begin
      k_d = rel_step ? (k_q + k_width_lp'(1)) : k_q;
    end

    reset_o_d = reset_o_q;
    unique case (state_d)
      HOLD, ASSERT: reset_o_d = '1;
      REL:          if (rel_step) reset_o_d[k_q] = 1'b0;
      RUN, DRAIN:   reset_o_d = '0;
      default:      reset_o_d = '1;
    endcase

    cnt_clear = (state_d != state_q) || ((state_q == HOLD) && tag_reset_i) || rel_step;
    cnt_up    = (state_q == HOLD) || (state_q == REL) || (state_q == DRAIN);
  end

  // Registered outputs and release index.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      k_q         <= '0;
      rtr_reset_q <= 1'b1;
      reset_o_q   <= '1;
      quiesce_q   <= 1'b0;
      ready_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      k_q         <= k_d;
      rtr_reset_q <= rtr_reset_d;
      reset_o_q   <= reset_o_d;
      quiesce_q   <= quiesce_d;
      ready_q     <= ready_d;
      timeout_q   <= timeout_d;
    end
  end

  assign rtr_reset_o = rtr_reset_q;
  assign reset_o     = reset_o_q;
  assign quiesce_o   = quiesce_q;
  assign ready_o     = ready_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_bsg_miniblade_io_reset_sequencer.sv
// Bench for the miniblade IO reset sequencer: directed scenarios plus random
// request/idle traffic, all outputs compared every cycle to a timeline model.
module tb_bsg_miniblade_io_reset_sequencer;

  localparam int ND = 2;
  localparam int HC = 16;
  localparam int ST = 4;
  localparam int TO = 64;

  logic          clk_i;
  logic          reset_i;
  logic          tag_reset_i;
  logic          idle_i;
  logic          rtr_reset_o;
  logic [ND-1:0] reset_o;
  logic          quiesce_o;
  logic          ready_o;
  logic          timeout_o;

  int n_checks;
  int n_pass;

  // Model: which phase of the timeline we are in, plus elapsed-cycle counters.
  bit m_hold, m_assert, m_run, m_drain, m_timeout;
  int m_hold_low;
  int m_rel_age;
  int m_drain_age;

  int t_rtr, t_r0, t_r1, t_rdy, qcnt;
  bit q_seen;

  bsg_miniblade_io_reset_sequencer #(
    .num_domains_p    (ND),
    .hold_cycles_p    (HC),
    .stagger_cycles_p (ST),
    .drain_timeout_p  (TO)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .tag_reset_i (tag_reset_i),
    .idle_i      (idle_i),
    .rtr_reset_o (rtr_reset_o),
    .reset_o     (reset_o),
    .quiesce_o   (quiesce_o),
    .ready_o     (ready_o),
    .timeout_o   (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog expired: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_hold = 1; m_assert = 0; m_run = 0; m_drain = 0; m_timeout = 0;
    m_hold_low = 0; m_rel_age = -1; m_drain_age = 0;
  endtask

  // One clock of the timeline, using the inputs seen at that edge.
  task automatic model_step(input bit t, input bit i);
    if (m_assert) begin
      m_assert = 0; m_hold = 1; m_hold_low = 0;
    end else if (m_hold) begin
      if (t) m_hold_low = 0;
      else begin
        m_hold_low++;
        if (m_hold_low == HC) begin m_hold = 0; m_rel_age = 0; end
      end
    end else if (m_rel_age >= 0) begin
      if (t) begin m_rel_age = -1; m_assert = 1; end
      else begin
        m_rel_age++;
        if (m_rel_age == ND * ST) begin m_rel_age = -1; m_run = 1; end
      end
    end else if (m_run) begin
      if (t) begin m_run = 0; m_drain = 1; m_drain_age = 0; end
    end else if (m_drain) begin
      if (i) begin m_drain = 0; m_assert = 1; end
      else begin
        m_drain_age++;
        if (m_drain_age == TO) begin m_drain = 0; m_assert = 1; m_timeout = 1; end
      end
    end
  endtask

  task automatic check_all();
    logic [ND-1:0] exp_rst;
    for (int d = 0; d < ND; d++)
      exp_rst[d] = m_hold || m_assert || (m_rel_age >= 0 && m_rel_age < (d + 1) * ST);
    check("rtr_reset_o", 32'(rtr_reset_o), 32'(m_hold || m_assert));
    check("reset_o",     32'(reset_o),     32'(exp_rst));
    check("quiesce_o",   32'(quiesce_o),   32'(m_drain));
    check("ready_o",     32'(ready_o),     32'(m_run));
    check("timeout_o",   32'(timeout_o),   32'(m_timeout));
  endtask

  task automatic step();
    @(posedge clk_i);
    model_step(tag_reset_i, idle_i);
    #1;
    check_all();
  endtask

  // Async reset pulse between clock edges; values must appear with no edge.
  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    check("async_rtr",     32'(rtr_reset_o), 32'h1);
    check("async_reset_o", 32'(reset_o),     32'h3);
    check("async_quiesce", 32'(quiesce_o),   32'h0);
    check("async_ready",   32'(ready_o),     32'h0);
    check("async_timeout", 32'(timeout_o),   32'h0);
    model_reset();
    #1;
    reset_i = 1'b0;
  endtask

  // Step and record the first edge (1-based) at which each release is seen.
  task automatic measure(input int steps);
    t_rtr = -1; t_r0 = -1; t_r1 = -1; t_rdy = -1; q_seen = 0;
    for (int n = 1; n <= steps; n++) begin
      step();
      if (t_rtr < 0 && rtr_reset_o === 1'b0)     t_rtr = n;
      if (t_r0  < 0 && reset_o[0] === 1'b0)      t_r0  = n;
      if (t_r1  < 0 && reset_o[ND-1] === 1'b0)   t_r1  = n;
      if (t_rdy < 0 && ready_o === 1'b1)         t_rdy = n;
      if (quiesce_o === 1'b1)                    q_seen = 1;
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    reset_i = 1'b1; tag_reset_i = 1'b0; idle_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    @(negedge clk_i);
    reset_i = 1'b0;

    // Power-on bring-up.
    measure(30);
    check("t1_rtr_edge",  32'(t_rtr), 32'd16);
    check("t1_r0_edge",   32'(t_r0),  32'd20);
    check("t1_r1_edge",   32'(t_r1),  32'd24);
    check("t1_rdy_edge",  32'(t_rdy), 32'd24);
    check("t1_no_quiesce", 32'(q_seen), 32'd0);

    // Request glitch in HOLD restarts the hold count.
    do_reset();
    repeat (10) step();
    tag_reset_i = 1'b1;
    repeat (3) step();
    tag_reset_i = 1'b0;
    measure(30);
    check("t2_rtr_after_glitch", 32'(t_rtr), 32'd16);
    check("t2_ready",            32'(ready_o), 32'd1);

    // Drain ended by idle, then re-bring-up after the request drops.
    tag_reset_i = 1'b1;
    step();
    check("t3_ready_falls",  32'(ready_o),   32'd0);
    check("t3_quiesce_rise", 32'(quiesce_o), 32'd1);
    qcnt = 1;
    repeat (4) begin step(); if (quiesce_o === 1'b1) qcnt++; end
    idle_i = 1'b1;
    step();
    idle_i = 1'b0;
    check("t3_quiesce_cycles", 32'(qcnt), 32'd5);
    check("t3_all_reset",      32'({rtr_reset_o, reset_o}), 32'h7);
    check("t3_no_timeout",     32'(timeout_o), 32'd0);
    repeat (3) step();
    tag_reset_i = 1'b0;
    measure(30);
    check("t3_rtr_edge", 32'(t_rtr), 32'd16);
    check("t3_r1_edge",  32'(t_r1),  32'd24);

    // Drain ended by timeout; flag stays through the next bring-up.
    tag_reset_i = 1'b1;
    qcnt = 0;
    repeat (70) begin step(); if (quiesce_o === 1'b1) qcnt++; end
    check("t4_quiesce_cycles", 32'(qcnt), 32'd64);
    check("t4_timeout_set",    32'(timeout_o), 32'd1);
    tag_reset_i = 1'b0;
    measure(30);
    check("t4_ready_after", 32'(ready_o),   32'd1);
    check("t4_timeout_sticky", 32'(timeout_o), 32'd1);

    // Request after router release but before domains: straight to assert.
    do_reset();
    repeat (18) step();
    check("t5_rtr_released", 32'(rtr_reset_o), 32'd0);
    check("t5_domains_held", 32'(reset_o),     32'h3);
    tag_reset_i = 1'b1;
    step();
    check("t5_rtr_reasserted", 32'(rtr_reset_o), 32'd1);
    check("t5_domains_reset",  32'(reset_o),     32'h3);
    check("t5_no_quiesce",     32'(quiesce_o),   32'd0);
    repeat (2) step();
    tag_reset_i = 1'b0;

    // Async reset mid-RUN, then a clean repeat of power-on.
    measure(30);
    check("t6_running", 32'(ready_o), 32'd1);
    do_reset();
    measure(30);
    check("t6_rtr_edge", 32'(t_rtr), 32'd16);
    check("t6_r0_edge",  32'(t_r0),  32'd20);
    check("t6_r1_edge",  32'(t_r1),  32'd24);
    check("t6_no_quiesce", 32'(q_seen), 32'd0);

    // Random request/idle traffic with occasional async resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) tag_reset_i = ~tag_reset_i;
      idle_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
